// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the compare arbiter slice.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } cmp_arb_state_e;

    // XOR mask that maps two's-complement order onto unsigned order
    localparam logic [31:0] SIGN_FLIP = 32'h8000_0000;

endpackage

// File: rtl/compare_32bit_u.sv
// Unsigned 32-bit magnitude comparator; exactly one output is high.
module compare_32bit_u (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        equal,
    output logic        alarger,
    output logic        blarger
);

    assign equal   = (a == b);
    assign alarger = (a > b);
    assign blarger = (a < b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the lowest-offset valid request at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [NREQ-1:0]          rot_req;
    logic [NREQ-1:0][IDW-1:0] pos;

    // rot_req[k] is the request sitting k places after the pointer
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW:0] sum;
            assign sum = {1'b0, ptr} + (IDW+1)'(gi);
            assign pos[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
            assign rot_req[gi] = req[pos[gi]];
        end
    endgenerate

    // Descending scan so the smallest offset is the one left standing
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                any          = 1'b1;
                idx          = pos[k];
                gnt          = '0;
                gnt[pos[k]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/compare_arbiter.sv
// Shares one unsigned comparator between NREQ requesters with round-robin grant
// and a registered single-entry response.
module compare_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ-1:0][31:0] req_a_i,
    input  logic [NREQ-1:0][31:0] req_b_i,
    input  logic [NREQ-1:0]       req_signed_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDW-1:0]        rsp_id_o,
    output logic                  rsp_equal_o,
    output logic                  rsp_alarger_o,
    output logic                  rsp_blarger_o,
    output logic                  busy_o
);

    cmp_arb_state_e state_reg, state_next;
    logic [IDW-1:0] ptr_reg;
    logic [31:0]    a_reg, b_reg;
    logic           signed_reg;
    logic [IDW-1:0] id_reg;
    logic           rsp_equal_reg, rsp_alarger_reg, rsp_blarger_reg;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic            accept;

    logic [31:0] cmp_a, cmp_b;
    logic        cmp_equal, cmp_alarger, cmp_blarger;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req (req_valid_i),
        .ptr (ptr_reg),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign accept = (state_reg == IDLE) && gnt_any;

    always_comb begin
        state_next  = state_reg;
        req_ready_o = '0;
        case (state_reg)
            IDLE: begin
                req_ready_o = gnt;
                if (gnt_any) state_next = CMP;
            end
            CMP:  state_next = RSP;
            RSP:  if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Signed compare reuses the unsigned comparator with bit 31 flipped on both sides
    assign cmp_a = signed_reg ? (a_reg ^ SIGN_FLIP) : a_reg;
    assign cmp_b = signed_reg ? (b_reg ^ SIGN_FLIP) : b_reg;

    compare_32bit_u u_cmp (
        .a       (cmp_a),
        .b       (cmp_b),
        .equal   (cmp_equal),
        .alarger (cmp_alarger),
        .blarger (cmp_blarger)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg         <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            signed_reg      <= 1'b0;
            id_reg          <= '0;
            rsp_equal_reg   <= 1'b0;
            rsp_alarger_reg <= 1'b0;
            rsp_blarger_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg      <= req_a_i[gnt_idx];
                b_reg      <= req_b_i[gnt_idx];
                signed_reg <= req_signed_i[gnt_idx];
                id_reg     <= gnt_idx;
                ptr_reg    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            end
            if (state_reg == CMP) begin
                rsp_equal_reg   <= cmp_equal;
                rsp_alarger_reg <= cmp_alarger;
                rsp_blarger_reg <= cmp_blarger;
            end
        end
    end

    assign rsp_valid_o   = (state_reg == RSP);
    assign rsp_id_o      = id_reg;
    assign rsp_equal_o   = rsp_equal_reg;
    assign rsp_alarger_o = rsp_alarger_reg;
    assign rsp_blarger_o = rsp_blarger_reg;
    assign busy_o        = (state_reg != IDLE);

endmodule
